// File: rtl/mem_sched.sv
// rtl/mem_sched.sv - single-port unified memory scheduler, data requests win over fetch
// Tracks one outstanding read at a time and steers the returned word to its owner.
module mem_sched #(
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_be,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              stall,
    output logic [15:0]       conflict_cnt
);

    typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

    localparam logic [1:0] LAT_INIT = 2'(MEM_LAT);

    state_t      state, state_nxt;
    logic [1:0]  lat_cnt, lat_nxt;
    logic [31:0] if_hold, d_hold;
    logic [15:0] cnt;
    logic        ret;

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^{if_addr[1:0], d_addr[1:0]};

    always_comb begin
        if_gnt    = 1'b0;
        d_gnt     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        state_nxt = state;
        lat_nxt   = lat_cnt;
        ret       = (state != IDLE) && (lat_cnt == 2'd1);

        if (state != IDLE) lat_nxt = lat_cnt - 2'd1;
        if (ret) state_nxt = IDLE;

        // The return cycle doubles as an issue slot so reads can run back to back.
        if (rst && ((state == IDLE) || ret)) begin
            if (d_req) begin
                d_gnt     = 1'b1;
                mem_en    = 1'b1;
                mem_addr  = d_addr[ADDR_W-1:2];
                mem_we    = d_we ? d_be : 4'b0000;
                mem_wdata = d_wdata;
                if (!d_we) begin
                    state_nxt = D_WAIT;
                    lat_nxt   = LAT_INIT;
                end
            end else if (if_req) begin
                if_gnt    = 1'b1;
                mem_en    = 1'b1;
                mem_addr  = if_addr[ADDR_W-1:2];
                state_nxt = I_WAIT;
                lat_nxt   = LAT_INIT;
            end
        end

        if_rvalid = ret && (state == I_WAIT);
        d_rvalid  = ret && (state == D_WAIT);
        if_rdata  = if_rvalid ? mem_rdata : if_hold;
        d_rdata   = d_rvalid ? mem_rdata : d_hold;
        stall     = rst && ((if_req && !if_gnt) || (d_req && !d_gnt) ||
                            ((state != IDLE) && !ret));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            lat_cnt <= 2'd0;
            if_hold <= 32'd0;
            d_hold  <= 32'd0;
            cnt     <= 16'd0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_nxt;
            if (if_rvalid) if_hold <= mem_rdata;
            if (d_rvalid) d_hold <= mem_rdata;
            if (if_req && d_req && d_gnt && (cnt != 16'hFFFF)) cnt <= cnt + 16'd1;
        end
    end

    assign conflict_cnt = cnt;

endmodule

// File: tb/tb_mem_sched.sv
// tb/tb_mem_sched.sv - scoreboard bench for mem_sched with a slot/timestamp reference model
module tb_mem_sched;

    localparam int LAT = 2;

    logic        clk, rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be, mem_we;
    logic        mem_en, stall;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [15:0] conflict_cnt;

    mem_sched #(.ADDR_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .stall(stall), .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int unsigned i);
        return (32'(i) * 32'h01000193) ^ 32'hC0FFEE11;
    endfunction

    function automatic logic [31:0] rand_addr();
        return $urandom & 32'hF00000FF;
    endfunction

    // Memory environment: byte-writable array, reads appear LAT cycles after issue.
    bit [31:0] env_arr [64];
    bit        env_wr  [64];
    bit        pv [LAT];
    bit [31:0] pd [LAT];
    logic [31:0] env_cur;

    always @(posedge clk) begin
        for (int i = 0; i < LAT - 1; i++) begin
            pv[i] <= pv[i+1];
            pd[i] <= pd[i+1];
        end
        env_cur = env_wr[mem_addr[5:0]] ? env_arr[mem_addr[5:0]] : init_word(mem_addr[5:0]);
        pv[LAT-1] <= mem_en && (mem_we == 4'b0000);
        pd[LAT-1] <= env_cur;
        if (mem_en && (mem_we != 4'b0000)) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) env_cur[8*b +: 8] = mem_wdata[8*b +: 8];
            env_arr[mem_addr[5:0]] <= env_cur;
            env_wr[mem_addr[5:0]]  <= 1'b1;
        end
    end
    assign mem_rdata = pv[0] ? pd[0] : 32'h0BAD0BAD;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t i_q[$];
    rsp_t d_q[$];

    // Reference model: a read occupies the port until issue+LAT, a store for one cycle.
    int          cyc, next_free;
    logic        allow, ed, ei, gd_flag, gi_flag;
    logic [15:0] cnt_m;
    logic [3:0]  exp_we;
    bit [31:0]   ref_arr [64];
    bit          ref_wr  [64];
    logic [31:0] ref_cur;
    logic [5:0]  ridx;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            cyc = 0; next_free = 0; cnt_m = 16'd0; gd_flag = 1'b0; gi_flag = 1'b0;
        end else begin
            allow = (cyc >= next_free);
            ed = allow && d_req;
            ei = allow && !d_req && if_req;
            chk("d_gnt", 32'(d_gnt), 32'(ed));
            chk("if_gnt", 32'(if_gnt), 32'(ei));
            chk("mem_en", 32'(mem_en), 32'(ed || ei));
            exp_we = (ed && d_we) ? d_be : 4'b0000;
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            if (ed) begin
                chk("mem_addr_d", 32'(mem_addr), d_addr >> 2);
                chk("mem_wdata", mem_wdata, d_wdata);
            end else if (ei) begin
                chk("mem_addr_i", 32'(mem_addr), if_addr >> 2);
            end
            chk("stall", 32'(stall),
                32'((if_req && !ei) || (d_req && !ed) || (cyc < next_free)));
            chk("conflict_cnt", 32'(conflict_cnt), 32'(cnt_m));
            if (if_req && d_req && ed && (cnt_m != 16'hFFFF)) cnt_m = cnt_m + 16'd1;
            ridx = ed ? d_addr[7:2] : if_addr[7:2];
            ref_cur = ref_wr[ridx] ? ref_arr[ridx] : init_word(ridx);
            if (ed && d_we) begin
                for (int b = 0; b < 4; b++)
                    if (d_be[b]) ref_cur[8*b +: 8] = d_wdata[8*b +: 8];
                ref_arr[ridx] = ref_cur;
                ref_wr[ridx]  = 1'b1;
                next_free = cyc + 1;
            end else if (ed) begin
                d_q.push_back('{data: ref_cur, due: cyc + LAT});
                next_free = cyc + LAT;
            end else if (ei) begin
                i_q.push_back('{data: ref_cur, due: cyc + LAT});
                next_free = cyc + LAT;
            end
            gd_flag = ed;
            gi_flag = ei;
            cyc++;
        end
    end

    // Monitor: pops expected read responses when the DUT presents rvalid.
    int          mcyc;
    logic        exp_v;
    logic [31:0] i_hold, d_hold;
    rsp_t        e;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            i_q.delete(); d_q.delete(); i_hold = 32'd0; d_hold = 32'd0; mcyc = 0;
        end else begin
            exp_v = (i_q.size() > 0) && (i_q[0].due == mcyc);
            chk("if_rvalid", 32'(if_rvalid), 32'(exp_v));
            if (exp_v) begin
                e = i_q.pop_front();
                if (if_rvalid) chk("if_rdata", if_rdata, e.data);
                i_hold = e.data;
            end else if (!if_rvalid) begin
                chk("if_rdata_hold", if_rdata, i_hold);
            end
            exp_v = (d_q.size() > 0) && (d_q[0].due == mcyc);
            chk("d_rvalid", 32'(d_rvalid), 32'(exp_v));
            if (exp_v) begin
                e = d_q.pop_front();
                if (d_rvalid) chk("d_rdata", d_rdata, e.data);
                d_hold = e.data;
            end else if (!d_rvalid) begin
                chk("d_rdata_hold", d_rdata, d_hold);
            end
            mcyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_i(input logic [31:0] a);
        int n = 0;
        if_req = 1'b1; if_addr = a;
        do begin step(); n++; end while (!gi_flag && n < 20);
        if (!gi_flag) chk("if_grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be);
        int n = 0;
        d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_be = be;
        do begin step(); n++; end while (!gd_flag && n < 20);
        if (!gd_flag) chk("d_grant_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_zero_outputs();
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
    endtask

    task automatic rand_cycles(input int n, input int pd, input int pi, input int pdrop);
        for (int k = 0; k < n; k++) begin
            if (d_req && !gd_flag) begin
                if ($urandom_range(99) < pdrop) d_req = 1'b0;
            end else if ($urandom_range(99) < pd) begin
                d_req = 1'b1; d_we = 1'($urandom_range(1)); d_addr = rand_addr();
                d_wdata = $urandom; d_be = 4'($urandom_range(15));
            end else begin
                d_req = 1'b0;
            end
            if (if_req && !gi_flag) begin
                if ($urandom_range(99) < pdrop) if_req = 1'b0;
            end else if ($urandom_range(99) < pi) begin
                if_req = 1'b1; if_addr = rand_addr();
            end else begin
                if_req = 1'b0;
            end
            step();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0;
        if_req = 1'b1; if_addr = 32'h44;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h88; d_wdata = 32'h1234; d_be = 4'hF;
        step();
        check_zero_outputs();
        if_req = 1'b0; d_req = 1'b0;
        step();
        rst = 1'b1;

        for (int k = 0; k < 3; k++) issue_i(32'(k * 4));
        if_req = 1'b0;
        repeat (LAT + 1) step();

        if_req = 1'b1; if_addr = 32'h10;
        issue_d(1'b0, 32'h100, 32'h0, 4'h0);
        d_req = 1'b0;
        issue_i(32'h10);
        if_req = 1'b0;

        issue_d(1'b1, 32'h203, 32'h0000A5A5, 4'b0011);
        d_req = 1'b0;
        step();

        issue_d(1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
        issue_d(1'b0, 32'h40, 32'h0, 4'h0);
        d_req = 1'b0;
        for (int k = 0; k < 4; k++) issue_i(32'h80 + 32'(k * 4));
        if_req = 1'b0;
        repeat (LAT + 2) step();
        chk("d_rdata_deadbeef", d_rdata, 32'hDEADBEEF);

        issue_d(1'b0, 32'h44, 32'h0, 4'h0);
        d_req = 1'b0; if_req = 1'b1; if_addr = 32'h8;
        step();
        if_req = 1'b0;
        repeat (LAT + 2) step();
        chk("idle_mem_en", 32'(mem_en), 32'd0);

        issue_i(32'hC);
        rst = 1'b0;
        #1;
        check_zero_outputs();
        if_req = 1'b0;
        repeat (2) step();
        rst = 1'b1;
        repeat (LAT + 4) step();

        rand_cycles(800, 40, 50, 5);
        rand_cycles(800, 70, 80, 10);
        rand_cycles(800, 15, 90, 20);

        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0; d_be = 4'hF; d_wdata = 32'h5A5A5A5A;
        if_req = 1'b1; if_addr = 32'h4;
        repeat (70000) step();
        d_req = 1'b0; if_req = 1'b0;
        repeat (LAT + 4) step();
        chk("conflict_saturated", 32'(conflict_cnt), 32'h0000FFFF);
        chk("i_q_drained", 32'(i_q.size()), 32'd0);
        chk("d_q_drained", 32'(d_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
